spi_slave_gen: RTL and testbench



---
 rtl/spi_slave_gen.sv | 173 +++++++++++++++++
 tb/tb_spi_slave_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen.sv
// SPI slave front-end: deserialises {cmd[1:0], payload} frames from MOSI and
// serialises RAM read data onto MISO, with abort, timeout and command checks.
module spi_slave_gen #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int F     = DATA_W + 2;
  localparam int CNT_W = $clog2(F);
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] RECV      = 3'd2;
  localparam logic [2:0] READ_WAIT = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [F-1:0]      sr_q, sr_d;
  logic [F-1:0]      rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              addr_pending_q, addr_pending_d;
  logic [F-1:0]      frame;
  logic [TO_W-1:0]   to_inc;

  // Frame as it will look once the bit currently on MOSI is shifted in.
  assign frame  = {sr_q[F-2:0], MOSI};
  assign to_inc = to_q + TO_W'(1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    to_d           = to_q;
    sr_d           = sr_q;
    rx_data_d      = rx_data_q;
    tx_sr_d        = tx_sr_q;
    miso_d         = miso_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    addr_pending_d = addr_pending_q;
    case (state_q)
      IDLE: if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n) begin
          state_d = IDLE;
        end else begin
          sr_d    = {{(F-1){1'b0}}, MOSI};
          cnt_d   = CNT_W'(F - 1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (cnt_q == CNT_W'(1)) begin
          sr_d      = frame;
          rx_data_d = frame;
          cnt_d     = '0;
          state_d   = DONE;
          case (frame[F-1:F-2])
            2'b10: begin
              rx_valid_d     = 1'b1;
              addr_pending_d = 1'b1;
            end
            2'b11: begin
              if (addr_pending_q) begin
                rx_valid_d = 1'b1;
                to_d       = '0;
                state_d    = READ_WAIT;
              end else begin
                frame_err_d = 1'b1;
              end
            end
            default: rx_valid_d = 1'b1;
          endcase
        end else begin
          sr_d  = frame;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ_WAIT: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (tx_valid) begin
          tx_sr_d = tx_data << 1;
          miso_d  = tx_data[DATA_W-1];
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = READ_DATA;
        end else if (to_inc == TO_W'(TX_TIMEOUT)) begin
          to_d           = '0;
          frame_err_d    = 1'b1;
          addr_pending_d = 1'b0;
          state_d        = DONE;
        end else begin
          to_d = to_inc;
        end
      end
      READ_DATA: begin
        // cnt_q counts bits still to be driven from the latched word.
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (cnt_q == '0) begin
          miso_d         = 1'b0;
          addr_pending_d = 1'b0;
          state_d        = DONE;
        end else begin
          miso_d  = tx_sr_q[DATA_W-1];
          tx_sr_d = tx_sr_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DONE: if (SS_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      to_q           <= '0;
      sr_q           <= '0;
      rx_data_q      <= '0;
      tx_sr_q        <= '0;
      miso_q         <= 1'b0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      addr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      sr_q           <= sr_d;
      rx_data_q      <= rx_data_d;
      tx_sr_q        <= tx_sr_d;
      miso_q         <= miso_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      addr_pending_q <= addr_pending_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: directed scenarios plus random transactions,
// checked against a transaction-level model of addr_pending and rx_data.
module tb_spi_slave_gen;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int F  = DW + 2;

  logic          clk, rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid, frame_err, busy;
  logic [F-1:0]  rx_data;
  logic [DW-1:0] tx_data;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: the pending read-address flag and the last loaded frame.
  bit           m_addr;
  logic [F-1:0] m_rx;

  spi_slave_gen #(.DATA_W(DW), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] cmd, input logic [DW-1:0] pay, input bit tv_last);
    logic [F-1:0] fr;
    bit ok;
    fr = {cmd, pay};
    SS_n = 1'b0;
    tick();
    chk("e0_busy", busy, 1);
    for (int i = F - 1; i >= 0; i--) begin
      MOSI = fr[i];
      if (i == 0 && tv_last) begin
        tx_valid = 1'b1;
        tx_data  = DW'($urandom);
      end
      tick();
      if (i > 0) begin
        chk("rx_hold", rx_data, m_rx);
        chk("mid_vld", rx_valid, 0);
        chk("mid_err", frame_err, 0);
      end
    end
    tx_valid = 1'b0;
    MOSI     = 1'($urandom);
    ok   = !(cmd == 2'b11 && !m_addr);
    m_rx = fr;
    if (cmd == 2'b10) m_addr = 1'b1;
    chk("rx_valid", rx_valid, 32'(ok));
    chk("frame_err", frame_err, 32'(!ok));
    chk("rx_data", rx_data, m_rx);
    chk("miso_rx", MISO, 0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
    chk("pulse_gone", rx_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", frame_err, 0);
  endtask

  task automatic read_out(input int wait_n, input logic [DW-1:0] d);
    for (int k = 0; k < wait_n; k++) begin
      tick();
      chk("rw_miso", MISO, 0);
      chk("rw_err", frame_err, 0);
      chk("rw_busy", busy, 1);
    end
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    chk("miso_msb", MISO, 32'(d[DW-1]));
    for (int i = DW - 2; i >= 0; i--) begin
      tx_valid = 1'($urandom);
      tx_data  = DW'($urandom);
      tick();
      chk("miso_bit", MISO, 32'(d[i]));
    end
    tick();
    tx_valid = 1'b0;
    chk("miso_end", MISO, 0);
    chk("rd_busy", busy, 1);
    chk("rd_err", frame_err, 0);
    m_addr = 1'b0;
  endtask

  task automatic timeout_run();
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("to_err", frame_err, 32'(k == TO));
      chk("to_miso", MISO, 0);
    end
    chk("to_busy", busy, 1);
    m_addr = 1'b0;
  endtask

  task automatic abort_run(input int nbits, input logic [1:0] cmd, input logic [DW-1:0] pay);
    logic [F-1:0] fr;
    fr   = {cmd, pay};
    SS_n = 1'b0;
    tick();
    for (int i = F - 1; i > F - 1 - nbits; i--) begin
      MOSI = fr[i];
      tick();
    end
    SS_n = 1'b1;
    tick();
    chk("ab_err", frame_err, 32'(nbits >= 1));
    chk("ab_busy", busy, 0);
    chk("ab_vld", rx_valid, 0);
    chk("ab_rx", rx_data, m_rx);
    chk("ab_miso", MISO, 0);
    tick();
    chk("ab_pulse", frame_err, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    m_addr   = 1'b0;
    m_rx     = '0;
    #12;
    chk("rst_miso", MISO, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_vld", rx_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    send_frame(2'b00, 8'hA5, 1'b0);
    chk("wr_a5", rx_data, 32'h0A5);
    end_frame();

    send_frame(2'b10, 8'h10, 1'b0);
    end_frame();
    send_frame(2'b11, 8'h00, 1'b1);
    read_out(2, 8'hC3);
    end_frame();

    send_frame(2'b11, DW'($urandom), 1'b0);
    chk("noaddr_miso", MISO, 0);
    end_frame();

    send_frame(2'b10, DW'($urandom), 1'b0);
    end_frame();
    send_frame(2'b11, DW'($urandom), 1'b0);
    timeout_run();
    end_frame();
    send_frame(2'b11, DW'($urandom), 1'b0);
    end_frame();

    abort_run(5, 2'b00, DW'($urandom));
    send_frame(2'b01, DW'($urandom), 1'b0);
    end_frame();
    abort_run(0, 2'b00, DW'($urandom));

    send_frame(2'b10, DW'($urandom), 1'b0);
    end_frame();
    send_frame(2'b11, DW'($urandom), 1'b0);
    SS_n = 1'b1;
    tick();
    chk("abwait_err", frame_err, 1);
    chk("abwait_busy", busy, 0);
    send_frame(2'b11, DW'($urandom), 1'b0);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("abdata_pre", MISO, 1);
    SS_n = 1'b1;
    tick();
    chk("abdata_err", frame_err, 1);
    chk("abdata_miso", MISO, 0);
    send_frame(2'b11, DW'($urandom), 1'b0);
    read_out(0, 8'h5A);
    end_frame();

    send_frame(2'b10, DW'($urandom), 1'b0);
    end_frame();
    send_frame(2'b11, DW'($urandom), 1'b0);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("ar_pre_miso", MISO, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_miso", MISO, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rx", rx_data, 0);
    m_addr = 1'b0;
    m_rx   = '0;
    SS_n   = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    send_frame(2'b11, DW'($urandom), 1'b0);
    end_frame();

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          send_frame({1'b0, 1'($urandom)}, DW'($urandom), 1'b0);
          end_frame();
        end
        1: begin
          send_frame(2'b10, DW'($urandom), 1'b0);
          end_frame();
        end
        2: begin
          if (m_addr) begin
            d = DW'($urandom);
            send_frame(2'b11, DW'($urandom), 1'($urandom));
            read_out(int'($urandom_range(0, TO - 1)), d);
          end else begin
            send_frame(2'b11, DW'($urandom), 1'b0);
          end
          end_frame();
        end
        3: abort_run(int'($urandom_range(0, F - 1)), 2'($urandom), DW'($urandom));
        default: begin
          if (m_addr) begin
            send_frame(2'b11, DW'($urandom), 1'b0);
            timeout_run();
            end_frame();
          end
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
